// File: rtl/vsq_buffer.sv
// Staging buffer for one 64-entry INT18 block ahead of the INT4 VSQ quantizer.
// Optional VSQ_BUF_OVF_EN adds sticky overflow flag and saturating count.
module vsq_buffer #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int LANES = 16,
  parameter int DW    = 18
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [LANES*DW-1:0]   i_data,
  output logic [LANES*DW-1:0]   o_run_data,
  output logic                  o_start,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [LANES*DW-1:0]   o_rd_data,
  output logic                  o_busy
`ifdef VSQ_BUF_OVF_EN
  ,
  output logic                  o_ovf,
  output logic [7:0]            o_ovf_cnt
`endif
);

  localparam int VW = LANES * DW;

  typedef enum logic {
    S_FILL,
    S_DRAIN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW:0]   drain_cnt;
  logic [AW:0]   drain_cnt_nxt;
  logic          start_nxt;
  logic          accept;

  logic [VW-1:0] mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_FILL;
      wr_ptr    <= '0;
      drain_cnt <= '0;
      o_start   <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      drain_cnt <= drain_cnt_nxt;
      o_start   <= start_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wr_ptr_nxt    = wr_ptr;
    drain_cnt_nxt = drain_cnt;
    start_nxt     = 1'b0;
    o_ready       = (state == S_FILL);
    o_busy        = (state == S_DRAIN);
    accept        = i_valid & o_ready;
    unique case (1'b1)
      (state == S_FILL): begin
        if (accept) begin
          // DEPTH is a power of two, so the increment wraps naturally
          wr_ptr_nxt = wr_ptr + AW'(1);
          if (wr_ptr == AW'(DEPTH - 1)) begin
            state_nxt     = S_DRAIN;
            start_nxt     = 1'b1;
            drain_cnt_nxt = '0;
          end
        end
      end
      (state == S_DRAIN): begin
        drain_cnt_nxt = drain_cnt + (AW+1)'(1);
        if (drain_cnt == (AW+1)'(DEPTH))
          state_nxt = S_FILL;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (accept)
      mem[wr_ptr] <= i_data;
  end

  assign o_rd_data  = mem[i_rd_addr];
  // Idle cycles present zero so the running max is never raised
  assign o_run_data = accept ? i_data : '0;

`ifdef VSQ_BUF_OVF_EN
  logic ovf_hit;
  assign ovf_hit = i_valid & ~o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ovf     <= 1'b0;
      o_ovf_cnt <= '0;
    end else if (ovf_hit) begin
      o_ovf <= 1'b1;
      if (o_ovf_cnt != 8'hFF)
        o_ovf_cnt <= o_ovf_cnt + 8'd1;
    end
  end
`endif

endmodule
